// File: rtl/fetch_decode_queue_pkg.sv
// -----------------------------------------------------------------------------
// fetch_decode_queue_pkg
//   Shared constants and helpers for the fetch/decode instruction queue.
//   - DATA_W_DEFAULT : default width of an instruction word and each PC field
//   - DEPTH_MIN/MAX  : legal range of queue depth (must also be a power of two)
//   - FIELDS         : number of DATA_W fields in a bundle (instr, PC, PC+4)
//   - bundle_w()     : width of one stored bundle
//   - is_pow2()      : power-of-two test used by the elaboration-time checks
//   An empty queue presents the all-zero bundle, which decode treats as a NOP.
// -----------------------------------------------------------------------------
package fetch_decode_queue_pkg;

    localparam int DATA_W_DEFAULT = 32;
    localparam int DEPTH_MIN      = 2;
    localparam int DEPTH_MAX      = 16;
    localparam int FIELDS         = 3;

    function automatic int bundle_w(input int data_w);
        return FIELDS * data_w;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage : fetch_decode_queue_pkg

// File: rtl/fetch_decode_queue_storage.sv
// -----------------------------------------------------------------------------
// fdq_storage
//   Register array holding the queued bundles.
//   Ports:
//     CLK      in   clock; writes happen on the rising edge
//     wr_en    in   write the bundle at wr_addr this edge
//     wr_addr  in   write pointer
//     wr_data  in   bundle to store {instr, pc, pc_plus4}
//     rd_addr  in   read pointer (head of queue)
//     rd_data  out  bundle at rd_addr, combinational read
// -----------------------------------------------------------------------------
module fdq_storage
    import fetch_decode_queue_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int DEPTH  = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int BW    = bundle_w(DATA_W)
) (
    input  logic          CLK,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [BW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [BW-1:0] rd_data
);

    logic [BW-1:0] mem [DEPTH];

    // NOTE: the array has no reset; stale contents are never visible because
    // the control logic gates the outputs whenever the queue is empty.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule : fdq_storage

// File: rtl/fetch_decode_queue.sv
// -----------------------------------------------------------------------------
// fetch_decode_queue
//   Instruction queue between fetch and decode. Buffers up to DEPTH bundles
//   (instruction, PC, PC+4) so fetch keeps running while decode is stalled.
//   Ports:
//     CLK                in   clock
//     RESET              in   synchronous, active-low reset
//     FLUSH              in   drop all entries and this cycle's incoming bundle
//     IN_VALID           in   fetch presents a bundle
//     IN_READY           out  queue has room (COUNT < DEPTH)
//     Instr1_IF          in   fetched instruction
//     Instr_PC_IF        in   PC of fetched instruction
//     Instr_PC_Plus4_IF  in   PC+4 of fetched instruction
//     STALL              in   decode frozen, head is held
//     OUT_VALID          out  head entry valid (COUNT != 0)
//     Instr1_OUT         out  head instruction, 0 when empty
//     Instr_PC_OUT       out  head PC, 0 when empty
//     Instr_PC_Plus4     out  head PC+4, 0 when empty
//     COUNT              out  occupancy 0..DEPTH
//     ALMOST_FULL        out  COUNT >= AF_LEVEL
// -----------------------------------------------------------------------------
module fetch_decode_queue
    import fetch_decode_queue_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEFAULT,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = DEPTH - 1,
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = AW + 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              FLUSH,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [DATA_W-1:0] Instr1_IF,
    input  logic [DATA_W-1:0] Instr_PC_IF,
    input  logic [DATA_W-1:0] Instr_PC_Plus4_IF,
    input  logic              STALL,
    output logic              OUT_VALID,
    output logic [DATA_W-1:0] Instr1_OUT,
    output logic [DATA_W-1:0] Instr_PC_OUT,
    output logic [DATA_W-1:0] Instr_PC_Plus4,
    output logic [CW-1:0]     COUNT,
    output logic              ALMOST_FULL
);

    localparam int BW = bundle_w(DATA_W);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_COUNT   = CW'(AF_LEVEL);

    // Elaboration-time parameter checks.
    if (!is_pow2(DEPTH) || DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_bad_depth
        $error("fetch_decode_queue: DEPTH must be a power of two in 2..16");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
        $error("fetch_decode_queue: AF_LEVEL must be in 1..DEPTH");
    end

    logic [AW-1:0] wr_ptr,  wr_ptr_n;
    logic [AW-1:0] rd_ptr,  rd_ptr_n;
    logic [CW-1:0] count,   count_n;
    logic          push,    pop;
    logic [BW-1:0] wr_bundle, head_bundle;

    // Flags come from registered occupancy only, so IN_READY ignores STALL
    // and a same-cycle pop: a full queue refuses a push even while draining.
    assign IN_READY    = (count != FULL_COUNT);
    assign OUT_VALID   = (count != '0);
    assign ALMOST_FULL = (count >= AF_COUNT);
    assign COUNT       = count;

    assign wr_bundle = {Instr1_IF, Instr_PC_IF, Instr_PC_Plus4_IF};

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        push     = RESET && !FLUSH && IN_VALID && IN_READY;
        pop      = RESET && !FLUSH && OUT_VALID && !STALL;
        wr_ptr_n = wr_ptr;
        rd_ptr_n = rd_ptr;
        count_n  = count;

        if (FLUSH) begin
            wr_ptr_n = '0;
            rd_ptr_n = '0;
            count_n  = '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push) wr_ptr_n = wr_ptr + AW'(1);
            if (pop)  rd_ptr_n = rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count_n = count + CW'(1);
                2'b01:   count_n = count - CW'(1);
                default: count_n = count;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr_n;
            rd_ptr <= rd_ptr_n;
            count  <= count_n;
        end
    end

    fdq_storage #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_storage (
        .CLK     (CLK),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (wr_bundle),
        .rd_addr (rd_ptr),
        .rd_data (head_bundle)
    );

    // Empty queue shows the all-zero NOP bundle instead of stale storage.
    always_comb begin
        Instr1_OUT     = '0;
        Instr_PC_OUT   = '0;
        Instr_PC_Plus4 = '0;
        if (OUT_VALID) begin
            {Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4} = head_bundle;
        end
    end

endmodule : fetch_decode_queue

// File: tb/tb_fetch_decode_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_decode_queue
//   Directed bench for fetch_decode_queue at DATA_W=32, DEPTH=4, AF_LEVEL=3.
//   Inputs change 1 time unit after the rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_fetch_decode_queue;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic              CLK = 1'b0;
    logic              RESET;
    logic              FLUSH;
    logic              IN_VALID;
    logic              IN_READY;
    logic [DATA_W-1:0] Instr1_IF;
    logic [DATA_W-1:0] Instr_PC_IF;
    logic [DATA_W-1:0] Instr_PC_Plus4_IF;
    logic              STALL;
    logic              OUT_VALID;
    logic [DATA_W-1:0] Instr1_OUT;
    logic [DATA_W-1:0] Instr_PC_OUT;
    logic [DATA_W-1:0] Instr_PC_Plus4;
    logic [CW-1:0]     COUNT;
    logic              ALMOST_FULL;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    fetch_decode_queue #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .AF_LEVEL (3)
    ) dut (
        .CLK               (CLK),
        .RESET             (RESET),
        .FLUSH             (FLUSH),
        .IN_VALID          (IN_VALID),
        .IN_READY          (IN_READY),
        .Instr1_IF         (Instr1_IF),
        .Instr_PC_IF       (Instr_PC_IF),
        .Instr_PC_Plus4_IF (Instr_PC_Plus4_IF),
        .STALL             (STALL),
        .OUT_VALID         (OUT_VALID),
        .Instr1_OUT        (Instr1_OUT),
        .Instr_PC_OUT      (Instr_PC_OUT),
        .Instr_PC_Plus4    (Instr_PC_Plus4),
        .COUNT             (COUNT),
        .ALMOST_FULL       (ALMOST_FULL)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Instruction word derived from its PC so every field is distinct.
    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return {pc[15:0], 16'h0013};
    endfunction

    task automatic present(input logic valid, input logic [31:0] pc);
        IN_VALID          = valid;
        Instr_PC_IF       = pc;
        Instr1_IF         = instr_of(pc);
        Instr_PC_Plus4_IF = pc + 32'd4;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Check the full visible state; exp_pc is ignored (expect zeros) when empty.
    task automatic check_state(input string tag, input int exp_count, input logic [31:0] exp_pc);
        logic        v;
        logic [31:0] pc;
        v  = (exp_count != 0);
        pc = v ? exp_pc : 32'd0;
        check({tag, ".count"},     64'(COUNT),          64'(exp_count));
        check({tag, ".out_valid"}, 64'(OUT_VALID),      64'(v));
        check({tag, ".in_ready"},  64'(IN_READY),       64'(exp_count < DEPTH));
        check({tag, ".af"},        64'(ALMOST_FULL),    64'(exp_count >= 3));
        check({tag, ".pc"},        64'(Instr_PC_OUT),   64'(pc));
        check({tag, ".instr"},     64'(Instr1_OUT),     64'(v ? instr_of(exp_pc) : 32'd0));
        check({tag, ".pc4"},       64'(Instr_PC_Plus4), 64'(v ? exp_pc + 32'd4 : 32'd0));
    endtask

    initial begin
        logic [31:0] model_q[$];
        logic [31:0] sent[$];
        logic [31:0] got[$];
        int          next_idx;
        int          cycles;
        logic        m_push, m_pop;

        // Reset held two cycles with fetch pushing: nothing may enter.
        RESET = 1'b0;
        FLUSH = 1'b0;
        STALL = 1'b0;
        present(1'b1, 32'h0000_0dea);
        step();
        step();
        check_state("reset", 0, 32'h0);

        // Pass-through: each bundle visible one cycle later, COUNT stays 1.
        RESET = 1'b1;
        present(1'b1, 32'h100); step(); check_state("pass0", 1, 32'h100);
        present(1'b1, 32'h104); step(); check_state("pass1", 1, 32'h104);
        present(1'b1, 32'h108); step(); check_state("pass2", 1, 32'h108);
        present(1'b0, 32'h0);   step(); check_state("pass_empty", 0, 32'h0);

        // Fill under stall; 5th bundle must be held off.
        STALL = 1'b1;
        present(1'b1, 32'h300); step(); check_state("fill1", 1, 32'h300);
        present(1'b1, 32'h304); step(); check_state("fill2", 2, 32'h300);
        present(1'b1, 32'h308); step(); check_state("fill3", 3, 32'h300);
        present(1'b1, 32'h30c); step(); check_state("fill4", 4, 32'h300);
        present(1'b1, 32'h310); step(); check_state("fill_hold", 4, 32'h300);

        // Full plus pop: pop happens, push refused that same cycle.
        STALL = 1'b0;
        step(); check_state("full_pop", 3, 32'h304);
        step(); check_state("drain_push", 3, 32'h308);
        present(1'b0, 32'h0);
        step(); check_state("drain1", 2, 32'h30c);
        step(); check_state("drain2", 1, 32'h310);
        step(); check_state("drain3", 0, 32'h0);

        // Flush with an incoming bundle: everything is dropped.
        STALL = 1'b1;
        present(1'b1, 32'h400); step();
        present(1'b1, 32'h404); step();
        present(1'b1, 32'h408); step(); check_state("pre_flush", 3, 32'h400);
        FLUSH = 1'b1;
        STALL = 1'b0;
        present(1'b1, 32'h40c); step(); check_state("flush", 0, 32'h0);
        FLUSH = 1'b0;
        present(1'b1, 32'h200); step(); check_state("post_flush", 1, 32'h200);
        present(1'b0, 32'h0);   step(); check_state("post_flush_pop", 0, 32'h0);

        // Wrap: 10 bundles through the queue with random STALL, modelled here.
        next_idx = 0;
        cycles   = 0;
        while ((next_idx < 10 || model_q.size() != 0) && cycles < 200) begin
            STALL = 1'($urandom_range(0, 1));
            if (next_idx < 10) present(1'b1, 32'h1000 + 32'(next_idx) * 32'd4);
            else               present(1'b0, 32'h0);
            m_push = IN_VALID && (model_q.size() < DEPTH);
            m_pop  = (model_q.size() != 0) && !STALL;
            if (m_pop)  got.push_back(model_q.pop_front());
            if (m_push) begin
                model_q.push_back(Instr_PC_IF);
                sent.push_back(Instr_PC_IF);
                next_idx++;
            end
            step();
            cycles++;
            check_state($sformatf("wrap_c%0d", cycles), model_q.size(),
                        (model_q.size() != 0) ? model_q[0] : 32'h0);
        end
        check("wrap_timeout", 64'(cycles < 200), 64'd1);
        check("wrap_len", 64'(got.size()), 64'd10);
        for (int i = 0; i < got.size() && i < 10; i++) begin
            check($sformatf("wrap_order%0d", i), 64'(got[i]), 64'(32'h1000 + 32'(i) * 32'd4));
        end

        // Mid-stream reset drops entries.
        STALL = 1'b1;
        present(1'b1, 32'h500); step(); check_state("pre_reset", 1, 32'h500);
        RESET = 1'b0;
        step(); check_state("mid_reset", 0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fetch_decode_queue

// File: doc/fetch_decode_queue.md
# fetch_decode_queue

Parametrised instruction queue between the fetch and decode stages, replacing the single-entry IF/ID latch. It buffers up to DEPTH fetched instruction bundles (instruction word, its PC, PC+4) so fetch can keep running while decode is stalled. It supports a valid/ready handshake on the fetch side, a stall input on the decode side, a whole-queue flush, and occupancy outputs for fetch throttling. When empty it presents an all-zero bundle (NOP bubble).

## Interface
- DATA_W, 32: width of the instruction word and of each PC field
- DEPTH, 4: number of entries; power of two, 2..16
- AF_LEVEL, DEPTH-1: occupancy at or above which ALMOST_FULL asserts; 1..DEPTH

- CLK  in  1  single clock; all state updates on rising edge
- RESET  in  1  reset, synchronous and active-low
- FLUSH  in  1  synchronous: discard all entries and the incoming bundle this cycle
- IN_VALID  in  1  fetch presents a bundle
- IN_READY  out  1  queue can accept a bundle (count < DEPTH)
- Instr1_IF  in  DATA_W  fetched instruction
- Instr_PC_IF  in  DATA_W  address of fetched instruction
- Instr_PC_Plus4_IF  in  DATA_W  address of following instruction
- STALL  in  1  decode frozen; head is not consumed
- OUT_VALID  out  1  head entry valid (count != 0)
- Instr1_OUT  out  DATA_W  head instruction; 0 when empty
- Instr_PC_OUT  out  DATA_W  head PC; 0 when empty
- Instr_PC_Plus4  out  DATA_W  head PC+4; 0 when empty
- COUNT  out  clog2(DEPTH)+1  current occupancy, 0..DEPTH
- ALMOST_FULL  out  1  COUNT >= AF_LEVEL

## Operation
- Storage: circular buffer of DEPTH bundles (3×DATA_W bits), write pointer, read pointer (clog2(DEPTH) bits each, wrap modulo DEPTH), occupancy counter.
- push = IN_VALID && IN_READY && !FLUSH; pop = OUT_VALID && !STALL && !FLUSH.
- push: write bundle at write pointer, write pointer +1. pop: read pointer +1.
- COUNT next = COUNT + push − pop; simultaneous push and pop leave COUNT unchanged.
- IN_READY depends only on COUNT (not on STALL or pop): full queue refuses a push even if a pop happens the same cycle.
- Outputs are the head entry muxed by read pointer, gated to 0 when COUNT == 0.
- Priority per edge: RESET low > FLUSH > push/pop.
- RESET low or FLUSH: pointers and COUNT to 0; storage contents need not be cleared (outputs are gated). Reset mid-stream drops all entries.
- Pushing while IN_READY low is ignored; fetch must hold its bundle.
- Pop with STALL high never occurs; head and outputs hold stable.

## Timing
- Reset values: IN_READY=1, OUT_VALID=0, COUNT=0, ALMOST_FULL=0, all data outputs 0.
- Latency: bundle pushed at edge N is on outputs after edge N if queue was empty (1 cycle fetch-to-decode, same as the old latch); no combinational bypass from inputs to outputs.
- Throughput: one push and one pop per cycle sustained.
- IN_READY, OUT_VALID, COUNT, ALMOST_FULL are functions of registered state only.
- FLUSH asserted at edge N: after edge N queue empty, OUT_VALID=0, IN_READY=1; bundle presented at N is lost.
- Pointer wrap: after DEPTH pushes write pointer returns to 0; order strictly FIFO across wrap.

## Structure
- Shared defines in config.v: default DATA_W, bundle width macro (3×DATA_W), NOP bundle value 0, DEPTH legal range.
- One sub-module is natural: fdq_storage (register array, synchronous write port, asynchronous read port indexed by read pointer). Control (pointers, counter, flags) stays in fetch_decode_queue.
- Elaboration-time check: DEPTH power of two within range, AF_LEVEL within 1..DEPTH.

## Test plan
- Reset: RESET low for 2 cycles with IN_VALID=1 -> COUNT=0, OUT_VALID=0, outputs 0, IN_READY=1.
- Pass-through: STALL=0, push PC 0x100,0x104,0x108 on consecutive cycles -> each appears one cycle later in order, COUNT stays 1.
- Fill under stall (DEPTH=4, AF_LEVEL=3): STALL=1, push 5 bundles -> COUNT=4, ALMOST_FULL from COUNT=3, IN_READY=0, 5th held; release STALL -> 4 drained in order, 5th accepted after first pop.
- Full plus pop: full queue, IN_VALID=1, STALL=0 -> pop occurs, push refused that cycle, COUNT=3.
- Flush: COUNT=3, FLUSH=1 with IN_VALID=1 -> next cycle COUNT=0, outputs 0; then push 0x200 -> appears next cycle.
- Wrap: 10 push/pop pairs through DEPTH=4 with random STALL -> output PC sequence matches input sequence exactly.
